dice_roller: RTL and testbench

//  Producer side of the dice game's roll handshake. Spins two 1..6 die counters while the player holds the button.

---
 rtl/dice_pkg.sv | 27 ++
 rtl/dice_roller_btn_debounce.sv | 46 ++++
 rtl/dice_roller.sv | 176 +++++++++++++++++
 tb/tb_dice_roller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller and the dice game controller:
// FSM state encoding, die range, sum/die widths and the die-advance helper.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DIE_MIN = 1;
    localparam int DIE_MAX = 6;
    localparam int SUM_W   = 4;
    localparam int DIE_W   = 3;

    // Next die face in the 1..6 cycle; any illegal encoding recovers to 1.
    function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] d);
        logic [DIE_W-1:0] n;
        if ((d >= DIE_W'(DIE_MAX)) || (d < DIE_W'(DIE_MIN))) begin
            n = DIE_W'(DIE_MIN);
        end else begin
            n = d + DIE_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/dice_roller_btn_debounce.sv
// Button conditioner used when DICE_DEBOUNCE_EN is defined: a 2-flop
// synchroniser followed by a stability counter. The output only follows
// the synchronised input after it has differed from the output for
// DEB_CYCLES consecutive cycles, so shorter glitches are ignored.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             dout_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw button and accept a new level once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dout_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r != dout_r) begin
                if (cnt_r >= CNT_W'(DEB_CYCLES - 1)) begin
                    dout_r <= sync2_r;
                    cnt_r  <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/dice_roller.sv
// Dice roller: producer side of the dice game's roll handshake.
// Spins two 1..6 dice while the player holds the button (and the game
// controller permits rolling), then captures their sum with a one-cycle
// sum_vld pulse in the same cycle rb falls.
// Optional feature macro: DICE_DEBOUNCE_EN (debounced button instead of a
// single registering flop).
module dice_roller
    import dice_pkg::*;
#(
    parameter int MIN_ROLL_CYCLES = 3,
    parameter int DEB_CYCLES      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             roll_en,
    output logic             rb,
    output logic [SUM_W-1:0] sum,
    output logic             sum_vld,
    output logic [DIE_W-1:0] die1,
    output logic [DIE_W-1:0] die2
);

    localparam int SPIN_W = $clog2(MIN_ROLL_CYCLES + 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DIE_W-1:0]  die1_r;
    logic [DIE_W-1:0]  die2_r;
    logic [SUM_W-1:0]  sum_r;
    logic              rb_r;
    logic              sum_vld_r;
    logic [SPIN_W-1:0] spin_cnt_r;
    logic              btn_q_s;
    logic              btn_q_d1_r;
    logic              seen_r;
    logic              armed_r;
    logic              btn_rise_s;
    logic              start_s;
    logic              adv_s;
    logic              cap_s;

`ifdef DICE_DEBOUNCE_EN
    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk (clk),
        .rst (rst),
        .din (btn),
        .dout(btn_q_s)
    );
`else
    logic btn_q_r;

    // Single registering flop on the raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q_r <= 1'b0;
        end else begin
            btn_q_r <= btn;
        end
    end

    assign btn_q_s = btn_q_r;
`endif

    assign btn_rise_s = btn_q_s & ~btn_q_d1_r;

    // Edge detection plus arming: a roll needs a press that follows an observed release,
    // so a button held through reset or since the last roll never starts one.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q_d1_r <= 1'b0;
            seen_r     <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            btn_q_d1_r <= btn_q_s;
            seen_r     <= 1'b1;
            if (start_s) begin
                armed_r <= 1'b0;
            end else if (seen_r && !btn_q_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Next-state decode; abort (roll_en low) outranks capture.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        adv_s       = 1'b0;
        cap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_rise_s && roll_en && armed_r) begin
                    state_nxt_s = ROLLING;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROLLING: begin
                if (!roll_en) begin
                    state_nxt_s = IDLE;
                end else if (!btn_q_s && (spin_cnt_r >= SPIN_W'(MIN_ROLL_CYCLES))) begin
                    state_nxt_s = DONE;
                    cap_s       = 1'b1;
                end else begin
                    state_nxt_s = ROLLING;
                    adv_s       = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs (rb tracks ROLLING, sum_vld marks DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rb_r      <= 1'b0;
            sum_vld_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rb_r      <= (state_nxt_s == ROLLING);
            sum_vld_r <= cap_s;
        end
    end

    // Die counters: die1 steps each advancing cycle, die2 steps when die1 wraps 6->1.
    always_ff @(posedge clk) begin
        if (rst) begin
            die1_r <= DIE_W'(DIE_MIN);
            die2_r <= DIE_W'(DIE_MIN);
        end else if (adv_s) begin
            die1_r <= die_next(die1_r);
            if (die1_r == DIE_W'(DIE_MAX)) begin
                die2_r <= die_next(die2_r);
            end
        end
    end

    // Spin counter: cleared at roll start, saturates at the minimum roll length.
    always_ff @(posedge clk) begin
        if (rst) begin
            spin_cnt_r <= '0;
        end else if (start_s) begin
            spin_cnt_r <= '0;
        end else if (adv_s && (spin_cnt_r < SPIN_W'(MIN_ROLL_CYCLES))) begin
            spin_cnt_r <= spin_cnt_r + SPIN_W'(1);
        end
    end

    // Sum register: loaded only on the capture cycle, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= '0;
        end else if (cap_s) begin
            sum_r <= SUM_W'(die1_r) + SUM_W'(die2_r);
        end
    end

    assign rb      = rb_r;
    assign sum     = sum_r;
    assign sum_vld = sum_vld_r;
    assign die1    = die1_r;
    assign die2    = die2_r;

endmodule

// File: tb/tb_dice_roller.sv
// Directed self-checking bench for dice_roller (default build, MIN_ROLL_CYCLES=3).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       roll_en = 1'b0;
    logic       rb;
    logic [3:0] sum;
    logic       sum_vld;
    logic [2:0] die1;
    logic [2:0] die2;

    int tests = 0;
    int fails = 0;
    int rb_cnt;
    int vld_seen;

    dice_roller #(
        .MIN_ROLL_CYCLES(3),
        .DEB_CYCLES     (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .roll_en(roll_en),
        .rb     (rb),
        .sum    (sum),
        .sum_vld(sum_vld),
        .die1   (die1),
        .die2   (die2)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    // Raise btn for 'hold' raw cycles, then wait (bounded) for the sum_vld pulse.
    // rb_cnt counts cycles with rb high; vld_seen is 1 if the pulse arrived.
    task automatic do_roll(input int hold, output int rbc, output int vs);
        btn = 1'b1;
        rbc = 0;
        vs  = 0;
        for (int i = 0; i < 100 && vs == 0; i++) begin
            step();
            if (i == hold - 1) btn = 1'b0;
            if (rb === 1'b1) rbc++;
            if (sum_vld === 1'b1) vs = 1;
        end
    endtask

    initial begin
        // 1. reset, then idle: all outputs at reset values throughout
        roll_en = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check("t1_idle", {die1, die2, sum, rb, sum_vld}, {3'd1, 3'd1, 4'd0, 1'b0, 1'b0});
            step();
        end

        // 2. btn_q high for 5 advancing cycles, then a non-advancing exit cycle
        roll_en = 1'b1;
        do_roll(6, rb_cnt, vld_seen);
        check("t2_vld", vld_seen, 1);
        check("t2_rb_cycles", rb_cnt, 6);
        check("t2_rb_fall", rb, 0);
        check("t2_sum", sum, 7);
        check("t2_die1", die1, 6);
        check("t2_die2", die2, 1);
        step();
        check("t2_vld_once", sum_vld, 0);
        check("t2_sum_hold", sum, 7);

        // 3. 6 advances -> (1,2) sum 3; 36 advances -> (1,1) sum 2
        do_reset();
        do_roll(7, rb_cnt, vld_seen);
        check("t3a_vld", vld_seen, 1);
        check("t3a_sum", sum, 3);
        check("t3a_dice", {die1, die2}, {3'd1, 3'd2});
        do_reset();
        do_roll(37, rb_cnt, vld_seen);
        check("t3b_vld", vld_seen, 1);
        check("t3b_sum", sum, 2);
        check("t3b_dice", {die1, die2}, {3'd1, 3'd1});

        // 4. 1-cycle press still spins the minimum 3 advances: (4,1) sum 5
        do_reset();
        do_roll(1, rb_cnt, vld_seen);
        check("t4_vld", vld_seen, 1);
        check("t4_rb_cycles", rb_cnt, 4);
        check("t4_sum", sum, 5);
        check("t4_dice", {die1, die2}, {3'd4, 3'd1});
        step();

        // 4b. rising edge with roll_en low is ignored
        roll_en = 1'b0;
        btn = 1'b1;
        step();
        btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4b_no_roll", rb, 0);
        end
        check("t4b_dice", {die1, die2}, {3'd4, 3'd1});
        roll_en = 1'b1;
        step();
        step();

        // 5. abort in ROLLING cycle 2: dice frozen at (5,1), sum stays 5, no pulse
        btn = 1'b1;
        step();
        check("t5_idle", rb, 0);
        step();
        check("t5_r1", rb, 1);
        step();
        check("t5_r2", rb, 1);
        check("t5_r2_die1", die1, 5);
        roll_en = 1'b0;
        step();
        check("t5_abort_rb", rb, 0);
        check("t5_abort_vld", sum_vld, 0);
        check("t5_abort_sum", sum, 5);
        check("t5_abort_dice", {die1, die2}, {3'd5, 3'd1});
        roll_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_held_no_restart", {rb, sum_vld}, {1'b0, 1'b0});
        end
        btn = 1'b0;
        step();
        step();
        do_roll(1, rb_cnt, vld_seen);
        check("t5_reroll_vld", vld_seen, 1);
        check("t5_reroll_sum", sum, 4);
        check("t5_reroll_dice", {die1, die2}, {3'd2, 3'd2});
        step();

        // 6. reset during ROLLING cycle 4, held button does not start a roll afterwards
        btn = 1'b1;
        step();
        step();
        step();
        step();
        step();
        check("t6_r4", rb, 1);
        rst = 1'b1;
        step();
        check("t6_reset", {die1, die2, sum, rb, sum_vld}, {3'd1, 3'd1, 4'd0, 1'b0, 1'b0});
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_held_after_reset", {rb, sum_vld}, {1'b0, 1'b0});
        end
        btn = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
